// File: rtl/bht_update_unit_pkg.sv
// Shared types for the in-order BHT training unit: update record, entry state and ring-age helper.
package bht_update_unit_pkg;

  localparam int unsigned VLEN         = 64;
  localparam int unsigned BhuIndexBits = 10;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef enum logic [1:0] {
    BhuFree     = 2'd0,
    BhuPending  = 2'd1,
    BhuResolved = 2'd2
  } bhu_state_e;

  typedef struct packed {
    bhu_state_e              state;
    logic [VLEN-1:0]         pc;
    logic                    pred_taken;
    logic                    taken;
    logic [BhuIndexBits-1:0] ghr;
  } bhu_entry_t;

  // Age is the distance from head around the ring; larger distance means younger.
  function automatic logic is_younger(input int unsigned tag, input int unsigned ref_tag,
                                      input int unsigned head, input int unsigned depth);
    int unsigned mask;
    mask = depth - 1;
    return ((tag - head) & mask) > ((ref_tag - head) & mask);
  endfunction

endpackage

// File: rtl/bht_update_unit.sv
// In-order BHT training producer: tracks branches, trains on resolution, squashes on mispredict.
// Optional perf counters are enabled with `define BHT_UPDATE_UNIT_PERF_EN.
module bht_update_unit
  import bht_update_unit_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned INDEX_BITS = BhuIndexBits,
  localparam int unsigned TAG_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [VLEN-1:0]       alloc_pc_i,
  input  logic                  alloc_taken_i,
  input  logic [INDEX_BITS-1:0] alloc_ghr_i,
  output logic [TAG_W-1:0]      alloc_tag_o,
  input  logic                  res_valid_i,
  input  logic [TAG_W-1:0]      res_tag_i,
  input  logic                  res_taken_i,
  output bht_update_t           bht_update_o,
  output logic                  mispredict_o,
  output logic [INDEX_BITS-1:0] restore_ghr_o,
`ifdef BHT_UPDATE_UNIT_PERF_EN
  output logic [31:0]           mispredict_cnt_o,
  output logic [31:0]           update_cnt_o,
`endif
  output logic [TAG_W:0]        count_o
);

  if (INDEX_BITS != BhuIndexBits || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("bht_update_unit: unsupported DEPTH/INDEX_BITS");
  end

  localparam logic [TAG_W:0] PtrOne = {{TAG_W{1'b0}}, 1'b1};

  bhu_entry_t r_entries [DEPTH];
  bhu_entry_t w_entries [DEPTH];
  logic [TAG_W:0] r_head, r_tail, w_head, w_tail;
  bht_update_t r_update, w_update;
  logic r_mispredict;
  logic [INDEX_BITS-1:0] r_restore_ghr, w_restore_ghr;

  logic [TAG_W-1:0] w_head_idx, w_tail_idx, w_res_off;
  logic w_full, w_alloc, w_res_ok, w_mispredict, w_mis_pulse, w_drain;
  bhu_entry_t w_head_entry, w_res_entry;

  assign w_head_idx   = r_head[TAG_W-1:0];
  assign w_tail_idx   = r_tail[TAG_W-1:0];
  assign w_head_entry = r_entries[w_head_idx];
  assign w_res_entry  = r_entries[res_tag_i];
  // Full when the pointers differ only in the wrap bit.
  assign w_full       = (r_head ^ r_tail) == {1'b1, {TAG_W{1'b0}}};
  assign w_alloc      = alloc_valid_i && !w_full;
  assign w_res_ok     = res_valid_i && (w_res_entry.state == BhuPending);
  assign w_mispredict = w_res_ok && (res_taken_i != w_res_entry.pred_taken);
  assign w_mis_pulse  = w_mispredict && !flush_i;
  assign w_drain      = w_head_entry.state == BhuResolved;
  assign w_res_off    = res_tag_i - w_head_idx;

  always_comb begin
    w_entries     = r_entries;
    w_head        = r_head;
    w_tail        = r_tail;
    w_update      = '0;
    w_restore_ghr = r_restore_ghr;
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_entries[i].state = BhuFree;
      end
      w_tail = r_head;
    end else begin
      if (w_drain) begin
        w_entries[w_head_idx].state = BhuFree;
        w_head = r_head + PtrOne;
        if (!debug_mode_i) begin
          w_update.valid = 1'b1;
          w_update.pc    = w_head_entry.pc;
          w_update.taken = w_head_entry.taken;
        end
      end
      if (w_res_ok) begin
        w_entries[res_tag_i].state = BhuResolved;
        w_entries[res_tag_i].taken = res_taken_i;
      end
      if (w_mispredict) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (is_younger(i, 32'(res_tag_i), 32'(w_head_idx), DEPTH)) begin
            w_entries[i].state = BhuFree;
          end
        end
        // Re-derive the wrap bit from head so the new tail lands right after the mispredict.
        w_tail        = r_head + {1'b0, w_res_off} + PtrOne;
        w_restore_ghr = (w_res_entry.ghr >> 1) |
                        ({{(INDEX_BITS-1){1'b0}}, res_taken_i} << (INDEX_BITS - 1));
      end else if (w_alloc) begin
        w_entries[w_tail_idx] = '{state: BhuPending, pc: alloc_pc_i, pred_taken: alloc_taken_i,
                                  taken: 1'b0, ghr: alloc_ghr_i};
        w_tail = r_tail + PtrOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_update      <= '0;
      r_mispredict  <= 1'b0;
      r_restore_ghr <= '0;
    end else begin
      r_entries     <= w_entries;
      r_head        <= w_head;
      r_tail        <= w_tail;
      r_update      <= w_update;
      r_mispredict  <= w_mis_pulse;
      r_restore_ghr <= w_restore_ghr;
    end
  end

`ifdef BHT_UPDATE_UNIT_PERF_EN
  logic [31:0] r_mispredict_cnt, r_update_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mispredict_cnt <= '0;
      r_update_cnt     <= '0;
    end else begin
      if (w_mis_pulse)    r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      if (w_update.valid) r_update_cnt     <= r_update_cnt + 32'd1;
    end
  end

  assign mispredict_cnt_o = r_mispredict_cnt;
  assign update_cnt_o     = r_update_cnt;
`endif

  assign alloc_ready_o = !w_full;
  assign alloc_tag_o   = w_tail_idx;
  assign bht_update_o  = r_update;
  assign mispredict_o  = r_mispredict;
  assign restore_ghr_o = r_restore_ghr;
  assign count_o       = r_tail - r_head;

  // Resolving a tag that is not in flight indicates a backend bookkeeping bug.
  a_res_pending: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    res_valid_i |-> (r_entries[res_tag_i].state == BhuPending));

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed and randomized checks of bht_update_unit against a queue-based reference model.
module tb_bht_update_unit;
  import bht_update_unit_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IB    = 10;
  localparam int unsigned TW    = 3;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, debug_mode_i;
  logic            alloc_valid_i, alloc_ready_o, alloc_taken_i;
  logic [VLEN-1:0] alloc_pc_i;
  logic [IB-1:0]   alloc_ghr_i, restore_ghr_o;
  logic [TW-1:0]   alloc_tag_o, res_tag_i;
  logic            res_valid_i, res_taken_i, mispredict_o;
  bht_update_t     bht_update_o;
  logic [TW:0]     count_o;
`ifdef BHT_UPDATE_UNIT_PERF_EN
  logic [31:0]     mispredict_cnt_o, update_cnt_o;
  int              m_mis_cnt, m_upd_cnt;
`endif

  always #5 clk_i = ~clk_i;

  bht_update_unit #(.DEPTH(DEPTH), .INDEX_BITS(IB)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .debug_mode_i  (debug_mode_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_pc_i    (alloc_pc_i),
    .alloc_taken_i (alloc_taken_i),
    .alloc_ghr_i   (alloc_ghr_i),
    .alloc_tag_o   (alloc_tag_o),
    .res_valid_i   (res_valid_i),
    .res_tag_i     (res_tag_i),
    .res_taken_i   (res_taken_i),
    .bht_update_o  (bht_update_o),
    .mispredict_o  (mispredict_o),
    .restore_ghr_o (restore_ghr_o),
`ifdef BHT_UPDATE_UNIT_PERF_EN
    .mispredict_cnt_o (mispredict_cnt_o),
    .update_cnt_o     (update_cnt_o),
`endif
    .count_o       (count_o)
  );

  // Reference model: in-flight branches kept oldest-first in a queue.
  typedef struct {
    int            tag;
    logic [63:0]   pc;
    logic          pred;
    logic [IB-1:0] ghr;
    bit            resolved;
    logic          actual;
  } ment_t;

  ment_t         mq[$];
  int            head_tag;
  bht_update_t   exp_upd;
  logic          exp_mis;
  logic [IB-1:0] exp_ghr;
  int            n_cmp, n_err;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("bht_update", bht_update_o, exp_upd);
    check_eq("mispredict", mispredict_o, exp_mis);
    check_eq("restore_ghr", restore_ghr_o, exp_ghr);
    check_eq("count", count_o, mq.size());
    check_eq("alloc_ready", alloc_ready_o, mq.size() < DEPTH);
    check_eq("alloc_tag", alloc_tag_o, (head_tag + mq.size()) % DEPTH);
`ifdef BHT_UPDATE_UNIT_PERF_EN
    check_eq("mispredict_cnt", mispredict_cnt_o, m_mis_cnt);
    check_eq("update_cnt", update_cnt_o, m_upd_cnt);
`endif
  endtask

  task automatic model_step();
    int new_tag, idx;
    bit full;
    logic [IB-1:0] g;
    new_tag = (head_tag + mq.size()) % DEPTH;
    full    = (mq.size() == DEPTH);
    idx     = -1;
    exp_upd = '0;
    exp_mis = 1'b0;
    if (flush_i) begin
      mq.delete();
      return;
    end
    if (mq.size() > 0 && mq[0].resolved) begin
      if (!debug_mode_i) begin
        exp_upd.valid = 1'b1;
        exp_upd.pc    = mq[0].pc;
        exp_upd.taken = mq[0].actual;
      end
      void'(mq.pop_front());
      head_tag = (head_tag + 1) % DEPTH;
    end
    if (res_valid_i) begin
      foreach (mq[k]) if (mq[k].tag == int'(res_tag_i) && !mq[k].resolved) idx = k;
    end
    if (idx >= 0) begin
      mq[idx].resolved = 1'b1;
      mq[idx].actual   = res_taken_i;
      if (res_taken_i != mq[idx].pred) begin
        exp_mis = 1'b1;
        g       = mq[idx].ghr;
        exp_ghr = {res_taken_i, g[IB-1:1]};
        while (mq.size() > idx + 1) void'(mq.pop_back());
      end
    end
    if (!exp_mis && alloc_valid_i && !full) begin
      mq.push_back('{tag: new_tag, pc: alloc_pc_i, pred: alloc_taken_i, ghr: alloc_ghr_i,
                     resolved: 1'b0, actual: 1'b0});
    end
`ifdef BHT_UPDATE_UNIT_PERF_EN
    if (exp_mis) m_mis_cnt++;
    if (exp_upd.valid) m_upd_cnt++;
`endif
  endtask

  task automatic cyc(input bit av, input logic [63:0] pc, input bit pt, input logic [IB-1:0] g,
                     input bit rv, input int rt, input bit rtk, input bit fl);
    alloc_valid_i = av;
    alloc_pc_i    = pc;
    alloc_taken_i = pt;
    alloc_ghr_i   = g;
    res_valid_i   = rv;
    res_tag_i     = TW'(rt);
    res_taken_i   = rtk;
    flush_i       = fl;
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0;
    alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_taken_i = 1'b0; alloc_ghr_i = '0;
    res_valid_i = 1'b0; res_tag_i = '0; res_taken_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    mq.delete(); head_tag = 0; exp_upd = '0; exp_mis = 1'b0; exp_ghr = '0;
`ifdef BHT_UPDATE_UNIT_PERF_EN
    m_mis_cnt = 0; m_upd_cnt = 0;
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    check_all();
  endtask

  task automatic rand_cycle();
    int pidx[$];
    int p, rt;
    bit rv, rtk, av, fl;
    foreach (mq[k]) if (!mq[k].resolved) pidx.push_back(k);
    rv  = (pidx.size() > 0) && ($urandom_range(99) < 55);
    rt  = 0;
    rtk = 1'($urandom_range(1));
    if (rv) begin
      p   = pidx[$urandom_range(pidx.size() - 1)];
      rt  = mq[p].tag;
      rtk = ($urandom_range(99) < 12) ? !mq[p].pred : mq[p].pred;
    end
    av = $urandom_range(99) < 60;
    fl = $urandom_range(199) == 0;
    if ($urandom_range(49) == 0) debug_mode_i = !debug_mode_i;
    cyc(av, {$urandom, $urandom}, 1'($urandom_range(1)), IB'($urandom), rv, rt, rtk, fl);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Single branch, correct prediction: update two cycles after resolution.
    do_reset();
    cyc(1, 64'h8000_0010, 1, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, '0, 1, 0, 1, 0);
    check_eq("t1_no_mispredict", mispredict_o, 1'b0);
    cyc(0, '0, 0, '0, 0, 0, 0, 0);
    check_eq("t1_update", bht_update_o, {1'b1, 64'h8000_0010, 1'b1});
    check_eq("t1_count", count_o, 0);

    // Out-of-order resolution, in-order training.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 64'h1000 + 64'(16 * i), 0, '0, 0, 0, 0, 0);
    cyc(0, '0, 0, '0, 1, 2, 0, 0);
    cyc(0, '0, 0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, '0, 1, 3, 0, 0);
    cyc(0, '0, 0, '0, 1, 1, 0, 0);
    idle(5);
    check_eq("t2_count", count_o, 0);

    // Mispredict squashes younger entries and the same-cycle allocation.
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1, 64'h2000 + 64'(4 * i), i == 2, (i == 2) ? 10'h155 : IB'($urandom), 0, 0, 0, 0);
    cyc(1, 64'hdead, 0, '0, 1, 2, 0, 0);
    check_eq("t3_mispredict", mispredict_o, 1'b1);
    check_eq("t3_restore_ghr", restore_ghr_o, 10'h0AA);
    check_eq("t3_count", count_o, 3);
    check_eq("t3_tag_reuse", alloc_tag_o, 3);
    cyc(0, '0, 0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, '0, 1, 1, 0, 0);
    idle(5);

    // Full ring: a same-cycle drain does not admit the blocked allocation.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 64'h3000 + 64'(i), 0, '0, 0, 0, 0, 0);
    cyc(1, 64'h3007, 0, '0, 1, 0, 0, 0);
    check_eq("t4_full_ready", alloc_ready_o, 1'b0);
    cyc(1, 64'h3008, 0, '0, 0, 0, 0, 0);
    check_eq("t4_blocked_count", count_o, 7);
    cyc(1, 64'h3008, 0, '0, 0, 0, 0, 0);
    check_eq("t4_refill_count", count_o, 8);
    for (int i = 0; i < 24; i++) begin
      int t;
      t = -1;
      foreach (mq[k]) if (t < 0 && !mq[k].resolved) t = mq[k].tag;
      cyc(1, 64'h4000 + 64'(i), 0, IB'(i), t >= 0, (t >= 0) ? t : 0, 0, 0);
    end
    idle(12);

    // Debug mode: entries drain silently.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 64'h5000 + 64'(i), 1, '0, 0, 0, 0, 0);
    debug_mode_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, '0, 1, i, 1, 0);
    idle(5);
    check_eq("t5_count", count_o, 0);
    debug_mode_i = 1'b0;

    // Flush overrides a same-cycle mispredicting resolve, allocation and drain.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 64'h6000 + 64'(i), 1, 10'h3ff, 0, 0, 0, 0);
    cyc(0, '0, 0, '0, 1, 0, 1, 0);
    cyc(1, 64'h6100, 0, '0, 1, 1, 0, 1);
    check_eq("t6_count", count_o, 0);
    check_eq("t6_mispredict", mispredict_o, 1'b0);
    check_eq("t6_update_valid", bht_update_o.valid, 1'b0);
    cyc(1, 64'h6200, 0, '0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) rand_cycle();
    debug_mode_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int t;
      t = -1;
      foreach (mq[k]) if (t < 0 && !mq[k].resolved) t = mq[k].tag;
      cyc(0, '0, 0, '0, t >= 0, (t >= 0) ? t : 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
